// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32 main FSM and its datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_source;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord,
        output alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
        output pc_source, fault, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord,
        input  alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg,
        input  pc_source, fault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath (R-type, LW, SW, BEQ),
// with a memory-stall watchdog that traps into a sticky FAULT state.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 into PC when memory is ready
// DECODE    | dispatch on opcode, branch target into ALUOut
// MEM_ADDR  | compute load/store address
// MEM_READ  | load data from memory
// MEM_WB    | write loaded data to the register file
// MEM_WRITE | store data to memory
// EXECUTE   | R-type ALU operation
// ALU_WB    | write ALU result to the register file
// BRANCH    | compare and conditionally take the branch
// FAULT     | sticky trap, left only by reset
module multicycle_control #(
    parameter int unsigned STALL_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    multicycle_control_if.master bus
);

    localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (STALL_TIMEOUT > 0) ? CW'(STALL_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_FAULT     = 4'd9
    } state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic       fault;
        logic       in_fetch;
        logic       in_branch;
    } ctrl_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    ctrl_t           ctrl_q;
    logic            waiting;
    logic            timeout_hit;

    // Outputs are registered from the next state so they decode the current state.
    function automatic ctrl_t decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.in_fetch  = 1'b1;
            end
            ST_DECODE:   c.alu_src_b = 2'b10;
            ST_MEM_ADDR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_EXECUTE: begin
                c.alu_src_a = 2'b01;
                c.aluop     = 2'b10;
            end
            ST_ALU_WB:   c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a = 2'b01;
                c.aluop     = 2'b01;
                c.pc_source = 1'b1;
                c.in_branch = 1'b1;
            end
            ST_FAULT:    c.fault = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d     = ST_FAULT;
        waiting     = 1'b0;
        timeout_hit = (STALL_TIMEOUT != 0) && (wait_q == CNT_LAST);
        case (state_q)
            ST_FETCH: begin
                waiting = 1'b1;
                if (bus.mem_ready)    state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_FAULT;
                else                  state_d = ST_FETCH;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_R:         state_d = ST_EXECUTE;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    default:      state_d = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LW)      state_d = ST_MEM_READ;
                else if (bus.opcode == OP_SW) state_d = ST_MEM_WRITE;
                else                          state_d = ST_FAULT;
            end
            ST_MEM_READ: begin
                waiting = 1'b1;
                if (bus.mem_ready)    state_d = ST_MEM_WB;
                else if (timeout_hit) state_d = ST_FAULT;
                else                  state_d = ST_MEM_READ;
            end
            ST_MEM_WRITE: begin
                waiting = 1'b1;
                if (bus.mem_ready)    state_d = ST_FETCH;
                else if (timeout_hit) state_d = ST_FAULT;
                else                  state_d = ST_MEM_WRITE;
            end
            ST_MEM_WB:  state_d = ST_FETCH;
            ST_EXECUTE: state_d = ST_ALU_WB;
            ST_ALU_WB:  state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_FAULT;
        endcase

        if (state_d != state_q)
            wait_d = '0;
        else if (waiting && !bus.mem_ready && (wait_q != CNT_MAX))
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            ctrl_q  <= decode(ST_FETCH);
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // Strobes are killed combinationally while reset is held.
    assign bus.pc_write   = !rst && ((ctrl_q.in_fetch && bus.mem_ready) ||
                                     (ctrl_q.in_branch && bus.zero));
    assign bus.ir_write   = !rst && ctrl_q.in_fetch && bus.mem_ready;
    assign bus.mem_read   = !rst && ctrl_q.mem_read;
    assign bus.mem_write  = !rst && ctrl_q.mem_write;
    assign bus.reg_write  = !rst && ctrl_q.reg_write;
    assign bus.iord       = ctrl_q.iord;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.aluop      = ctrl_q.aluop;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.pc_source  = ctrl_q.pc_source;
    assign bus.fault      = ctrl_q.fault;
    assign bus.state      = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle RV32 datapath (R-type, LW, SW, BEQ subset).
- Sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Drives the 2-bit aluop consumed by the ALU control decoder: 00 = add, 01 = subtract/compare, 10 = decode from funct.
- Stalls on a memory ready handshake, with a watchdog that traps to a sticky FAULT state.

Parameters:
STALL_TIMEOUT, 15, number of consecutive mem_ready=0 cycles in a wait state before entering FAULT; 0 disables the watchdog.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  instr[6:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  PC register load enable
ir_write  output  1  instruction register load enable
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
alu_src_a  output  2  ALU A select: 00 = PC, 01 = reg A
alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = immediate
aluop  output  2  to ALU control decoder
reg_write  output  1  register file write enable
mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
pc_source  output  1  PC select: 0 = ALU result, 1 = ALUOut (branch target)
fault  output  1  sticky trap indicator
state  output  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, FAULT=9.
- Unused encodings go to FAULT on the next edge.
- Outputs not listed for a state are 0.
- Outputs decode the current state. Only pc_write and ir_write also depend combinationally on mem_ready and zero.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00, pc_source=0.
  - ir_write = pc_write = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=00, alu_src_b=10, aluop=00 (branch target into ALUOut).
  - Next state by opcode: 0110011 -> EXECUTE; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; any other -> FAULT.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, aluop=00.
  - LW -> MEM_READ; SW -> MEM_WRITE.
  - opcode is held stable by the IR.
- MEM_READ: mem_read=1, iord=1. mem_ready=1 -> MEM_WB; otherwise stay.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1. mem_ready=1 -> FETCH; otherwise stay.
- EXECUTE: alu_src_a=01, alu_src_b=00, aluop=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, aluop=01, pc_source=1, pc_write=zero -> FETCH.
- FAULT: all strobes 0, fault=1. Stays until rst.
- Instruction latency with mem_ready=1 on first request:
  - R-type 4 cycles, LW 5, SW 4, BEQ 3.
  - Each stall cycle adds one.
- Watchdog counter wait_cnt, width clog2(STALL_TIMEOUT+1):
  - Cleared on every state transition.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - When wait_cnt==STALL_TIMEOUT-1 and mem_ready=0 in such a state -> FAULT next edge. FAULT is therefore entered after exactly STALL_TIMEOUT non-ready cycles.
  - mem_ready=1 in the same cycle takes priority over the timeout.
  - Counter saturates; never wraps.
- Reset:
  - While rst=1, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0 combinationally.
  - On the edge with rst=1: state<=FETCH, wait_cnt<=0, fault<=0.
  - Reset mid-operation abandons the instruction and the outstanding memory request. The first cycle after rst deasserts is FETCH.
- The memory request (mem_read/mem_write) stays held steady until mem_ready.

Test Plan:
- R-type add (opcode 0110011), mem_ready=1 throughout -> state 0,1,6,7,0; aluop=10 in EXECUTE; reg_write=1 only in ALU_WB.
- LW with mem_ready low for 2 cycles in MEM_READ -> state 0,1,2,3,3,3,4,0; mem_read and iord held 1 through the stall; mem_to_reg=1 in MEM_WB.
- BEQ: zero=1 -> pc_write=1, pc_source=1, aluop=01 in BRANCH. Repeat with zero=0 -> pc_write=0. Return to FETCH in both.
- STALL_TIMEOUT=3, mem_ready held 0 in FETCH -> FAULT after 3 FETCH cycles; fault=1 sticky for 10+ cycles; rst pulse -> FETCH, fault=0.
- Illegal opcode 1111111 in DECODE -> FAULT; no reg_write or mem_write ever asserted.
- Ready-vs-timeout tie (STALL_TIMEOUT=3, mem_ready=1 on 3rd cycle) -> DECODE, not FAULT.
- rst=1 during MEM_WRITE stall -> mem_write=0 same cycle; state=FETCH after the edge.
